// File: rtl/udp_rx_pkt_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : udp_rx_pkt_buf_pkg                                        |
// | Purpose  : Shared types and constants for the UDP receive packet     |
// |            buffer: write/read FSM encodings, default payload limit   |
// |            and a saturating counter helper.                          |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package udp_rx_pkt_buf_pkg;

  // Largest UDP payload that fits a standard 1500-byte Ethernet MTU.
  localparam int c_max_len_default = 1472;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_SEND = 2'd2
  } rd_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage : udp_rx_pkt_buf_pkg
`default_nettype wire

// File: rtl/udp_rx_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : udp_rx_dpram                                              |
// | Purpose  : Simple dual-port byte RAM, one write port and one read    |
// |            port with a registered (1-cycle) read.                    |
// | Ports    : clk        - clock                                        |
// |            rst        - sync reset, clears only the read register    |
// |            wr_en_i    - write strobe                                 |
// |            wr_addr_i  - write address                                |
// |            wr_data_i  - write data                                   |
// |            rd_en_i    - read strobe; read register holds when low    |
// |            rd_addr_i  - read address                                 |
// |            rd_data_o  - registered read data                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module udp_rx_dpram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register doubles as the consumer-facing data register, so it
  // must hold its value whenever no new read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : udp_rx_dpram
`default_nettype wire

// File: rtl/udp_rx_pkt_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : udp_rx_pkt_buf                                            |
// | Purpose  : Store-and-forward buffer for received UDP payloads. A     |
// |            frame is committed only when exactly rx_length bytes      |
// |            arrived and space exists; otherwise it is dropped and     |
// |            counted. Committed frames stream out with valid/ready.    |
// | Ports    : rgmii_clk  - clock          rst        - sync reset       |
// |            rx_valid   - input strobe   rx_data    - input byte       |
// |            rx_length  - payload length                               |
// |            out_valid/out_data/out_last/out_length - output frame     |
// |            out_ready  - consumer accept                              |
// |            drop_cnt   - saturating dropped-frame count               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module udp_rx_pkt_buf
  import udp_rx_pkt_buf_pkg::*;
#(
  parameter int BUF_AW   = 11,
  parameter int LFIFO_AW = 3,
  parameter int MAX_LEN  = c_max_len_default
) (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [15:0] rx_length,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] out_length,
  output logic [15:0] drop_cnt
);

  localparam int c_depth  = 1 << BUF_AW;
  localparam int c_frames = 1 << LFIFO_AW;

  wr_state_e         wr_state_q;
  rd_state_e         rd_state_q;
  logic [BUF_AW:0]   wr_ptr_q, cmt_ptr_q, rd_ptr_q;
  logic [15:0]       wr_len_q, wr_cnt_q, drop_cnt_q;
  logic              rx_valid_prev_q;
  logic [15:0]       lfifo_q [c_frames];
  logic [LFIFO_AW:0] lf_wr_q, lf_rd_q, pend_q;
  logic              out_valid_q, out_last_q;
  logic [15:0]       out_len_q, rd_idx_q;

  logic [BUF_AW:0]   free_bytes;
  logic              len_ok, fits, lf_full, lf_empty, frame_start, accept;
  logic              recv_wr, ram_we, commit, last_acc, ram_re;

  // rd_ptr_q is the fetch pointer: the byte sitting in the RAM read register
  // is already out of the array, so its slot can safely be reused.
  assign free_bytes  = (BUF_AW+1)'(c_depth) - (cmt_ptr_q - rd_ptr_q);
  assign len_ok      = (rx_length != 16'd0) && (32'(rx_length) <= 32'(MAX_LEN));
  assign fits        = 32'(free_bytes) >= 32'(rx_length);
  // Frame capacity counts frames not yet fully delivered, including the one
  // being output, so at most 2^LFIFO_AW frames are ever outstanding.
  assign lf_full     = pend_q == (LFIFO_AW+1)'(c_frames);
  assign lf_empty    = lf_wr_q == lf_rd_q;
  assign frame_start = rx_valid && !rx_valid_prev_q;
  assign accept      = frame_start && len_ok && fits && !lf_full;
  assign recv_wr     = (wr_state_q == W_RECV) && rx_valid && (wr_cnt_q < wr_len_q);
  assign ram_we      = ((wr_state_q == W_IDLE) && accept) || recv_wr;
  assign commit      = (wr_state_q == W_RECV) && !rx_valid && (wr_cnt_q == wr_len_q);
  assign last_acc    = (rd_state_q == R_SEND) && out_ready && out_last_q;
  assign ram_re      = (rd_state_q == R_LOAD) ||
                       ((rd_state_q == R_SEND) && out_ready && !out_last_q);

  udp_rx_dpram #(.AW(BUF_AW), .DW(8)) u_ram (
    .clk       (rgmii_clk),
    .rst       (rst),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q[BUF_AW-1:0]),
    .wr_data_i (rx_data),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[BUF_AW-1:0]),
    .rd_data_o (out_data)
  );

  // Write FSM
  always_ff @(posedge rgmii_clk) begin
    // Tracked through reset so the tail of a frame cut by reset is not
    // mistaken for the start of a new frame.
    rx_valid_prev_q <= rx_valid;
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      lf_wr_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (rx_valid) begin
            if (!frame_start) begin
              wr_state_q <= W_DROP;       // remainder of a reset-cut frame
            end else if (accept) begin
              wr_ptr_q   <= wr_ptr_q + 1'b1;
              wr_cnt_q   <= 16'd1;
              wr_len_q   <= rx_length;
              wr_state_q <= W_RECV;
            end else begin
              drop_cnt_q <= sat_inc16(drop_cnt_q);
              wr_state_q <= W_DROP;
            end
          end
        end
        W_RECV: begin
          if (rx_valid) begin
            if (recv_wr) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              wr_cnt_q <= wr_cnt_q + 16'd1;
            end
          end else begin
            if (commit) begin
              lf_wr_q   <= lf_wr_q + 1'b1;
              cmt_ptr_q <= wr_ptr_q;
            end else begin
              wr_ptr_q   <= cmt_ptr_q;
              drop_cnt_q <= sat_inc16(drop_cnt_q);
            end
            wr_state_q <= W_IDLE;
          end
        end
        W_DROP: begin
          if (!rx_valid) begin
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (commit) begin
      lfifo_q[lf_wr_q[LFIFO_AW-1:0]] <= wr_len_q;
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      case ({commit, last_acc})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      rd_ptr_q    <= '0;
      lf_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_len_q   <= '0;
      rd_idx_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (!lf_empty) begin
            rd_state_q <= R_LOAD;
          end
        end
        R_LOAD: begin
          out_len_q   <= lfifo_q[lf_rd_q[LFIFO_AW-1:0]];
          out_last_q  <= lfifo_q[lf_rd_q[LFIFO_AW-1:0]] == 16'd1;
          lf_rd_q     <= lf_rd_q + 1'b1;
          rd_ptr_q    <= rd_ptr_q + 1'b1;
          rd_idx_q    <= 16'd1;
          out_valid_q <= 1'b1;
          rd_state_q  <= R_SEND;
        end
        R_SEND: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              rd_state_q  <= lf_empty ? R_IDLE : R_LOAD;
            end else begin
              // Prefetch issued on this accept delivers the next byte
              // on the following cycle.
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              rd_idx_q   <= rd_idx_q + 16'd1;
              out_last_q <= (rd_idx_q + 16'd1) == out_len_q;
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_length = out_len_q;
  assign drop_cnt   = drop_cnt_q;

endmodule : udp_rx_pkt_buf
`default_nettype wire

// File: tb/tb_udp_rx_pkt_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_udp_rx_pkt_buf                                         |
// | Purpose  : Self-checking bench for udp_rx_pkt_buf. A frame-level     |
// |            model decides which frames survive and what bytes must    |
// |            come out; a monitor collects every accepted output byte.  |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_udp_rx_pkt_buf;

  localparam int c_maxl  = 1472;
  localparam int c_bufsz = 2048;
  localparam int c_nfr   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [15:0] rx_length = '0;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [15:0] out_length, drop_cnt;

  always #5 clk = ~clk;

  udp_rx_pkt_buf dut (
    .rgmii_clk  (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_length  (rx_length),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .out_length (out_length),
    .drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // 0 = ready low, 1 = ready high, 2 = random ready
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: records accepted bytes and checks hold-during-stall.
  logic [7:0]  got_data[$];
  logic        got_last[$];
  logic [15:0] got_len[$];
  int          hold_err = 0;
  logic        pstall = 1'b0;
  logic [7:0]  pd;
  logic        pl;
  logic [15:0] plen;

  always @(negedge clk) begin
    if (pstall && !rst && (out_valid !== 1'b1 || out_data !== pd ||
                           out_last !== pl || out_length !== plen)) begin
      hold_err++;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      got_len.push_back(out_length);
    end
    pstall = (out_valid === 1'b1) && (out_ready === 1'b0) && !rst;
    pd     = out_data;
    pl     = out_last;
    plen   = out_length;
  end

  // Reference model: expected output stream and occupancy
  logic [7:0]  exp_data[$];
  logic        exp_last[$];
  logic [15:0] exp_len[$];
  int base = 0;
  int mdl_drops = 0;
  int mdl_pend_bytes = 0;
  int mdl_pend_frames = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_data.delete();
    exp_last.delete();
    exp_len.delete();
    base            = got_data.size();
    mdl_pend_bytes  = 0;
    mdl_pend_frames = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = '0;
    rx_length = '0;
    rdy_mode  = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    clear_model();
    mdl_drops = 0;
  endtask

  task automatic send_frame(input int nbytes, input int len, input bit ramp);
    logic [7:0] b[$];
    bit good;
    for (int i = 0; i < nbytes; i++) b.push_back(ramp ? 8'(i) : 8'($urandom));
    for (int i = 0; i < nbytes; i++) begin
      rx_valid  = 1'b1;
      rx_data   = b[i];
      rx_length = 16'(len);
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = '0;
    tick();
    tick();
    good = (len >= 1) && (len <= c_maxl) && (nbytes >= len) &&
           (mdl_pend_bytes + len <= c_bufsz) && (mdl_pend_frames < c_nfr);
    if (good) begin
      for (int i = 0; i < len; i++) begin
        exp_data.push_back(b[i]);
        exp_last.push_back(i == len - 1);
        exp_len.push_back(16'(len));
      end
      mdl_pend_bytes  += len;
      mdl_pend_frames += 1;
    end else begin
      mdl_drops++;
    end
  endtask

  task automatic drain(input int mode, input string tag);
    int cyc, got, bad_d, bad_l, bad_n, ncmp;
    rdy_mode = mode;
    cyc = 0;
    while ((got_data.size() - base) < exp_data.size() && cyc < 8 * exp_data.size() + 200) begin
      tick();
      cyc++;
    end
    repeat (20) tick();
    rdy_mode = 0;
    got  = got_data.size() - base;
    ncmp = (got < exp_data.size()) ? got : exp_data.size();
    n_checks++;
    if (got !== exp_data.size())
      $display("FAIL %s byte count: got %0d expected %0d", tag, got, exp_data.size());
    else n_pass++;
    bad_d = -1; bad_l = -1; bad_n = -1;
    for (int i = 0; i < ncmp; i++) begin
      if (bad_d < 0 && got_data[base+i] !== exp_data[i]) bad_d = i;
      if (bad_l < 0 && got_last[base+i] !== exp_last[i]) bad_l = i;
      if (bad_n < 0 && got_len[base+i]  !== exp_len[i])  bad_n = i;
    end
    n_checks++;
    if (bad_d >= 0)
      $display("FAIL %s data at byte %0d: got %02h expected %02h", tag, bad_d,
               got_data[base+bad_d], exp_data[bad_d]);
    else n_pass++;
    n_checks++;
    if (bad_l >= 0)
      $display("FAIL %s out_last at byte %0d: got %0b expected %0b", tag, bad_l,
               got_last[base+bad_l], exp_last[bad_l]);
    else n_pass++;
    n_checks++;
    if (bad_n >= 0)
      $display("FAIL %s out_length at byte %0d: got %0d expected %0d", tag, bad_n,
               got_len[base+bad_n], exp_len[bad_n]);
    else n_pass++;
    n_checks++;
    if (hold_err !== 0) $display("FAIL %s stall hold: got %0d violations expected 0", tag, hold_err);
    else n_pass++;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %0b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset out_last: got %0b expected 0", out_last); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset out_data: got %02h expected 00", out_data); else n_pass++;
    n_checks++; if (out_length !== 16'd0) $display("FAIL reset out_length: got %0d expected 0", out_length); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset drop_cnt: got %0d expected 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_single_frame();
    do_reset();
    rdy_mode = 1;
    send_frame(16, 16, 1'b1);
    n_checks++; if (drop_cnt !== 16'(mdl_drops)) $display("FAIL single drop_cnt: got %0d expected %0d", drop_cnt, mdl_drops); else n_pass++;
    drain(1, "single");
  endtask

  task automatic test_short_frame();
    do_reset();
    rdy_mode = 1;
    send_frame(7, 10, 1'b0);
    repeat (10) tick();
    n_checks++; if (got_data.size() - base !== 0) $display("FAIL short_no_output: got %0d bytes expected 0", got_data.size() - base); else n_pass++;
    n_checks++; if (drop_cnt !== 16'(mdl_drops)) $display("FAIL short drop_cnt: got %0d expected %0d", drop_cnt, mdl_drops); else n_pass++;
    send_frame(12, 12, 1'b0);
    drain(1, "after_short");
  endtask

  task automatic test_buffer_full();
    do_reset();
    send_frame(1472, 1472, 1'b0);
    send_frame(300, 300, 1'b0);
    send_frame(300, 300, 1'b0);
    n_checks++; if (drop_cnt !== 16'(mdl_drops)) $display("FAIL buf_full drop_cnt: got %0d expected %0d", drop_cnt, mdl_drops); else n_pass++;
    drain(1, "buf_full");
  endtask

  task automatic test_fifo_full();
    int b0, nlast;
    do_reset();
    for (int k = 0; k < 9; k++) send_frame(4, 4, 1'b0);
    n_checks++; if (drop_cnt !== 16'(mdl_drops)) $display("FAIL fifo_full drop_cnt: got %0d expected %0d", drop_cnt, mdl_drops); else n_pass++;
    b0 = base;
    drain(1, "fifo_full");
    nlast = 0;
    for (int i = b0; i < got_last.size(); i++) if (got_last[i]) nlast++;
    n_checks++; if (nlast !== 8) $display("FAIL fifo_full last pulses: got %0d expected 8", nlast); else n_pass++;
  endtask

  task automatic test_random_ready();
    do_reset();
    rdy_mode = 2;
    send_frame(1472, 1472, 1'b0);
    send_frame(5, 0, 1'b0);
    send_frame(1473, 1473, 1'b0);
    drain(2, "rand_ready");
    n_checks++; if (drop_cnt !== 16'(mdl_drops)) $display("FAIL bad_len drop_cnt: got %0d expected %0d", drop_cnt, mdl_drops); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    rdy_mode = 1;
    send_frame(60, 60, 1'b0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_output active: got %0b expected 1", out_valid); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid out_valid: got %0b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL rst_mid out_last: got %0b expected 0", out_last); else n_pass++;
    repeat (10) tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid empty: got out_valid %0b expected 0", out_valid); else n_pass++;
    clear_model();
    mdl_drops = 0;
    // Reset lands in the middle of an incoming frame
    for (int i = 0; i < 20; i++) begin
      rx_valid  = 1'b1;
      rx_data   = 8'($urandom);
      rx_length = 16'd20;
      rst       = (i == 6);
      tick();
    end
    rst      = 1'b0;
    rx_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_in_frame drop_cnt: got %0d expected 0", drop_cnt); else n_pass++;
    send_frame(8, 8, 1'b0);
    drain(1, "after_rst_in_frame");
  endtask

  task automatic test_random(input int nfr, input int mode, input string tag);
    int kind, len, nb;
    do_reset();
    rdy_mode = mode;
    for (int k = 0; k < nfr; k++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin len = $urandom_range(2, 150); nb = $urandom_range(1, len - 1); end
        1: begin len = $urandom_range(1, 150); nb = len + $urandom_range(1, 5); end
        2: begin len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1500, 2000); nb = 3; end
        default: begin len = $urandom_range(1, 150); nb = len; end
      endcase
      send_frame(nb, len, 1'b0);
    end
    n_checks++; if (drop_cnt !== 16'(mdl_drops)) $display("FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt, mdl_drops); else n_pass++;
    drain(2, tag);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_short_frame();
    test_buffer_full();
    test_fifo_full();
    test_random_ready();
    test_reset_mid();
    test_random(10, 0, "random_stalled");
    test_random(6, 2, "random_streaming");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_udp_rx_pkt_buf
`default_nettype wire

// File: doc/udp_rx_pkt_buf.md
UDP_RX_PKT_BUF -- requirements
Module: udp_rx_pkt_buf

Interface
REQ-001 SHALL have parameter BUF_AW, default 11, meaning byte-buffer address width (2^BUF_AW bytes).
REQ-002 SHALL have parameter LFIFO_AW, default 3, meaning length-FIFO address width (up to 8 committed frames).
REQ-003 SHALL have parameter MAX_LEN, default 1472, meaning largest accepted UDP payload in bytes.
REQ-004 Port rgmii_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port rx_valid, input, 1: payload byte strobe from the UDP receive path.
REQ-007 Port rx_data, input, 8: payload byte, qualified by rx_valid.
REQ-008 Port rx_length, input, 16: payload length, stable while rx_valid is high.
REQ-009 Port out_valid, output, 1: out_data is presented.
REQ-010 Port out_data, output, 8: frame byte to the consumer.
REQ-011 Port out_last, output, 1: final byte of the current frame.
REQ-012 Port out_ready, input, 1: consumer accepts the byte when out_valid and out_ready are both high.
REQ-013 Port out_length, output, 16: length of the frame being output, valid while out_valid is high.
REQ-014 Port drop_cnt, output, 16: count of dropped frames, saturating at 16'hFFFF.

Function
REQ-015 A frame SHALL be one contiguous run of rx_valid-high cycles.
REQ-016 Write FSM SHALL use states W_IDLE, W_RECV and W_DROP.
REQ-017 W_IDLE SHALL leave on the first rx_valid cycle: to W_RECV if 1<=rx_length<=MAX_LEN, free bytes >= rx_length and the length FIFO is not full; otherwise to W_DROP.
REQ-018 In W_RECV, each rx_valid byte SHALL be written at wr_ptr, including the first byte, and wr_ptr SHALL increment modulo 2^BUF_AW.
REQ-019 Bytes beyond rx_length while rx_valid stays high SHALL be discarded; the frame still commits.
REQ-020 When rx_valid falls in W_RECV: if bytes written == rx_length, the block SHALL commit by pushing the length to the length FIFO and advancing the committed pointer to wr_ptr; otherwise it SHALL drop the frame and rewind wr_ptr to the committed pointer.
REQ-021 W_DROP SHALL write nothing and SHALL return to W_IDLE when rx_valid falls.
REQ-022 Each drop SHALL increment drop_cnt by 1, and the committed-data state SHALL be unchanged.
REQ-023 Read FSM SHALL use states R_IDLE, R_LOAD and R_SEND.
REQ-024 R_IDLE SHALL go to R_LOAD when the length FIFO is non-empty.
REQ-025 R_LOAD SHALL pop the length, issue a RAM read (1-cycle latency) and enter R_SEND with out_valid high, 2 cycles after the FIFO became non-empty.
REQ-026 In R_SEND, out_data, out_last and out_length SHALL hold while out_valid is high and out_ready is low.
REQ-027 In R_SEND, the next byte SHALL be prefetched so that a continuously high out_ready gives one byte per cycle.
REQ-028 out_last SHALL be high exactly on byte number out_length.
REQ-029 When the last byte is accepted, the read FSM SHALL go to R_LOAD if another frame is committed, else to R_IDLE.
REQ-030 Free bytes SHALL be 2^BUF_AW minus the committed-but-unread count; a commit and a byte read in the same cycle SHALL both take effect.
REQ-031 Address arithmetic SHALL use BUF_AW+1-bit pointers so that a full buffer is distinct from an empty one.

Reset
REQ-032 On rst, both FSMs SHALL go to idle, all pointers and the FIFO SHALL clear, and drop_cnt SHALL be 0.
REQ-033 On rst, out_valid, out_last, out_data and out_length SHALL be 0.
REQ-034 Reset during a frame SHALL discard it; remaining rx_valid bytes of that frame SHALL go to W_DROP without incrementing drop_cnt.
REQ-035 RAM contents SHALL not need a reset.

Structure
REQ-036 FSM state encodings and the MAX_LEN default SHALL live in the shared eth package.
REQ-037 The byte buffer SHALL be the sub-module udp_rx_dpram: simple dual-port, registered read.
REQ-038 The length FIFO SHALL be inline registers.

Verification
REQ-039 One 16-byte frame (0x00..0x0F) with out_ready=1 SHALL produce 16 bytes in order, out_last on 0x0F and out_length=16.
REQ-040 A frame with rx_length=10 but only 7 bytes SHALL give no output, drop_cnt=1, and the next good frame SHALL be intact.
REQ-041 Frames of 1472, 300 and 300 bytes into a 2048-byte buffer with out_ready=0 SHALL commit the 1472-byte and first 300-byte frames and drop the second 300-byte frame (drop_cnt=1).
REQ-042 Nine 4-byte frames with out_ready=0 SHALL commit 8 and drop the 9th; then releasing out_ready SHALL output 32 bytes with 8 out_last pulses.
REQ-043 Random out_ready during a 1472-byte frame SHALL keep data intact; rx_length=0 or 1473 SHALL each drop.
REQ-044 rst asserted mid-output SHALL give out_valid=0 the next cycle and an empty buffer.
